// File: rtl/load_extend_ctrl.sv
// Load controller: issues one doubleword read per load, selects the lane and extends it for writeback.
// Define LOAD_SIGNED_EN to add the i_req_signed port and sign extension; without it all loads zero-extend.
module load_extend_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic [4:0]  i_req_rd,
`ifdef LOAD_SIGNED_EN
    input  logic        i_req_signed,
`endif
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [63:0] i_mem_rdata,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [63:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_err,
    output logic        o_busy
);

    // state  | meaning
    // IDLE   | waiting for a load request
    // ISSUE  | mem_req strobe for one cycle
    // WAIT   | waiting for mem_ack, timeout counter running
    // WB     | result held until writeback consumes it
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [4:0]  r_rd;
    logic [63:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        r_err;
    logic        w_aligned;
    logic        w_accept;
    logic        w_timeout;
    logic        w_sign_en;
    logic [5:0]  w_shamt;
    logic [63:0] w_lane;
    logic [63:0] w_ext;

`ifdef LOAD_SIGNED_EN
    logic        r_signed;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_signed <= 1'b0;
        end else if (w_accept && w_aligned) begin
            r_signed <= i_req_signed;
        end
    end

    assign w_sign_en = r_signed;
`else
    assign w_sign_en = 1'b0;
`endif

    always_comb begin
        w_aligned = 1'b1;
        case (i_req_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~i_req_addr[0];
            2'b10:   w_aligned = (i_req_addr[1:0] == 2'b00);
            default: w_aligned = (i_req_addr[2:0] == 3'b000);
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && i_req_valid;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_aligned) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_mem_ack)      w_state_nxt = S_WB;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_WB:    if (i_wb_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift the addressed lane down to bit 0; alignment is guaranteed at accept.
    always_comb begin
        w_shamt = 6'd0;
        case (r_size)
            2'b00:   w_shamt = {r_addr[2:0], 3'b000};
            2'b01:   w_shamt = {r_addr[2:1], 4'b0000};
            2'b10:   w_shamt = {r_addr[2], 5'b00000};
            default: w_shamt = 6'd0;
        endcase
    end

    assign w_lane = i_mem_rdata >> w_shamt;

    always_comb begin
        w_ext = w_lane;
        case (r_size)
            2'b00:   w_ext = {{56{w_sign_en & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_ext = {{48{w_sign_en & w_lane[15]}}, w_lane[15:0]};
            2'b10:   w_ext = {{32{w_sign_en & w_lane[31]}}, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_addr    <= 64'd0;
            r_size    <= 2'b00;
            r_rd      <= 5'd0;
            r_wb_data <= 64'd0;
            r_wb_rd   <= 5'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (w_accept && !w_aligned) ||
                       ((r_state == S_WAIT) && !i_mem_ack && w_timeout);
            if (w_accept && w_aligned) begin
                r_addr <= i_req_addr;
                r_size <= i_req_size;
                r_rd   <= i_req_rd;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= 8'd0;
            end else if ((r_state == S_WAIT) && !i_mem_ack && !w_timeout) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Tag moves with the data so both stay stable after the handshake.
            if ((r_state == S_WAIT) && i_mem_ack) begin
                r_wb_data <= w_ext;
                r_wb_rd   <= r_rd;
            end
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_mem_req   = (r_state == S_ISSUE);
    assign o_mem_addr  = {r_addr[63:3], 3'b000};
    assign o_wb_valid  = (r_state == S_WB);
    assign o_wb_data   = r_wb_data;
    assign o_wb_rd     = r_wb_rd;
    assign o_err       = r_err;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Directed self-checking bench for load_extend_ctrl; sign-extension cases run when LOAD_SIGNED_EN is defined.
module tb_load_extend_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
`ifdef LOAD_SIGNED_EN
    logic        req_signed;
`endif
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_extend_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_size  (req_size),
        .i_req_rd    (req_rd),
`ifdef LOAD_SIGNED_EN
        .i_req_signed(req_signed),
`endif
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_wb_valid  (wb_valid),
        .i_wb_ready  (wb_ready),
        .o_wb_data   (wb_data),
        .o_wb_rd     (wb_rd),
        .o_err       (err),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, follow it through ISSUE, return positioned in the first WAIT cycle.
    task automatic accept(input logic [63:0] addr, input logic [1:0] size, input logic [4:0] rd);
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_rd    = rd;
        check("ready_in_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("issue_mem_req", mem_req, 1);
        check("issue_mem_addr", mem_addr, {addr[63:3], 3'b000});
        check("issue_busy", busy, 1);
        check("issue_not_ready", req_ready, 0);
        tick();
        check("wait_mem_req_low", mem_req, 0);
        check("wait_no_wb_valid", wb_valid, 0);
    endtask

    // Full load acked on the first WAIT cycle, then a one-cycle writeback handshake.
    task automatic load_full(input string tag, input logic [63:0] addr, input logic [1:0] size,
                             input logic [4:0] rd, input logic [63:0] data, input logic [63:0] exp);
        accept(addr, size, rd);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
        check({tag, "_wb_valid_lat3"}, wb_valid, 1);
        check({tag, "_wb_data"}, wb_data, exp);
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'(rd));
        check({tag, "_no_err"}, err, 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check({tag, "_wb_valid_drop"}, wb_valid, 0);
        check({tag, "_wb_data_retained"}, wb_data, exp);
        check({tag, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        int n;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 64'd0;
        req_size  = 2'b00;
        req_rd    = 5'd0;
`ifdef LOAD_SIGNED_EN
        req_signed = 1'b0;
`endif
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        wb_ready  = 1'b0;

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        reset = 1'b0;
        tick();
        check("rst_ready_after", req_ready, 1);

        // Byte lane 3 of 0x0011223344556677 is 0x44.
        load_full("byte", 64'h1003, 2'b00, 5'd7, 64'h0011_2233_4455_6677, 64'h44);

        // Stray ack in IDLE must not disturb the held result.
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_no_wb", wb_valid, 0);
        check("idle_ack_data_kept", wb_data, 64'h44);

        // Misaligned half load.
        req_valid = 1'b1;
        req_addr  = 64'h2001;
        req_size  = 2'b01;
        req_rd    = 5'd3;
        tick();
        req_valid = 1'b0;
        check("misalign_err", err, 1);
        check("misalign_no_mem_req", mem_req, 0);
        check("misalign_ready", req_ready, 1);
        check("misalign_not_busy", busy, 0);
        tick();
        check("misalign_err_pulse", err, 0);
        check("misalign_still_idle", mem_req, 0);

        // Word load, no ack: error after TIMEOUT WAIT cycles.
        accept(64'h3004, 2'b10, 5'd9);
        n = 0;
        while (err !== 1'b1 && n < 4 * TIMEOUT) begin
            tick();
            n++;
            if (wb_valid !== 1'b0) check("timeout_no_wb_valid", wb_valid, 0);
        end
        check("timeout_cycles", 64'(n), 64'(TIMEOUT));
        check("timeout_idle_ready", req_ready, 1);
        check("timeout_not_busy", busy, 0);
        tick();
        check("timeout_err_pulse", err, 0);

        // Ack arriving on the last WAIT cycle wins over the timeout.
        accept(64'h3004, 2'b10, 5'd10);
        repeat (TIMEOUT - 1) tick();
        check("last_cycle_no_err_yet", err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h8899_AABB_CCDD_EEFF;
        tick();
        mem_ack = 1'b0;
        check("last_cycle_wb_valid", wb_valid, 1);
        check("last_cycle_no_err", err, 0);
        check("last_cycle_word_hi", wb_data, 64'h0000_0000_8899_AABB);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("last_cycle_consumed", wb_valid, 0);
        tick();
        check("last_cycle_err_quiet", err, 0);

        load_full("word_lo", 64'h0010, 2'b10, 5'd11, 64'h8899_AABB_CCDD_EEFF, 64'h0000_0000_CCDD_EEFF);
        load_full("half_l3", 64'h4006, 2'b01, 5'd12, 64'h8899_AABB_CCDD_EEFF, 64'h0000_0000_0000_8899);
        load_full("half_l1", 64'h4002, 2'b01, 5'd13, 64'h8899_AABB_CCDD_EEFF, 64'h0000_0000_0000_CCDD);
        load_full("byte_l0", 64'h0000, 2'b00, 5'd14, 64'h1234_5678_90AB_CD80, 64'h80);

        // Dword with writeback stalled for 5 cycles; a stray ack during WB is ignored.
        accept(64'h5000, 2'b11, 5'd21);
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_wb_valid", wb_valid, 1);
            check("hold_wb_data", wb_data, 64'hDEAD_BEEF_0123_4567);
            check("hold_wb_rd", 64'(wb_rd), 64'd21);
            check("hold_not_ready", req_ready, 0);
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'h1111_1111_1111_1111;
            end
            tick();
            mem_ack = 1'b0;
        end
        check("hold_cycle6_valid", wb_valid, 1);
        check("hold_cycle6_data", wb_data, 64'hDEAD_BEEF_0123_4567);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("hold_consumed", wb_valid, 0);
        check("hold_ready_after", req_ready, 1);

        // Reset during WAIT, then a late ack.
        accept(64'h6008, 2'b11, 5'd25);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'h7777_7777_7777_7777;
        tick();
        mem_ack = 1'b0;
        check("rstwait_no_wb_valid", wb_valid, 0);
        check("rstwait_no_err", err, 0);
        check("rstwait_not_busy", busy, 0);
        check("rstwait_wb_data", wb_data, 64'd0);
        check("rstwait_wb_rd", 64'(wb_rd), 64'd0);
        check("rstwait_mem_addr", mem_addr, 64'd0);
        check("rstwait_mem_req", mem_req, 0);
        check("rstwait_ready", req_ready, 1);
        tick();
        check("rstwait_later_no_wb", wb_valid, 0);
        check("rstwait_later_no_err", err, 0);

        // Reset while holding a result in WB.
        accept(64'h7000, 2'b11, 5'd30);
        mem_ack   = 1'b1;
        mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("rstwb_pre_valid", wb_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstwb_wb_valid", wb_valid, 0);
        check("rstwb_wb_data", wb_data, 64'd0);
        check("rstwb_err", err, 0);

`ifdef LOAD_SIGNED_EN
        req_signed = 1'b1;
        load_full("sbyte_neg", 64'h0000, 2'b00, 5'd1, 64'h1234_5678_90AB_CD80, 64'hFFFF_FFFF_FFFF_FF80);
        load_full("shalf_neg", 64'h4006, 2'b01, 5'd2, 64'h8899_AABB_CCDD_EEFF, 64'hFFFF_FFFF_FFFF_8899);
        load_full("sword_pos", 64'h0010, 2'b10, 5'd3, 64'h8899_AABB_7CDD_EEFF, 64'h0000_0000_7CDD_EEFF);
        load_full("sdword", 64'h0018, 2'b11, 5'd4, 64'h8899_AABB_CCDD_EEFF, 64'h8899_AABB_CCDD_EEFF);
        req_signed = 1'b0;
        load_full("ubyte", 64'h0000, 2'b00, 5'd5, 64'h1234_5678_90AB_CD80, 64'h0000_0000_0000_0080);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
